// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the fetch sequencer
package core_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int INSTR_W    = 32;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Clear wins over increment; the count sticks at all-ones instead of wrapping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter owner and instruction fetch sequencer
module fetch_sequencer
    import core_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int CNT_W    = 16,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               imem_halt,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               halted,
    output logic               overrun,
    output logic               misaligned,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   retired_count
);

    localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);
    // Byte address of the last word in memory (2**ADDR_W - 4)
    localparam logic [ADDR_W-1:0] LAST_PC    = ~ADDR_W'(WORD_BYTES - 1);

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic              overrun_q;
    logic              misaligned_q;

    logic              in_run;
    logic              advance;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_raw;
    logic [ADDR_W-1:0] redirect_pc;
    logic              at_last_word;
    logic              restart;

    // Redirect selection and advance qualification; jump beats branch
    always_comb begin
        in_run       = (state_q == RUN);
        advance      = in_run && !imem_halt && !stall;
        redirect     = jump || branch_taken;
        redirect_raw = jump ? jump_target : branch_target;
        redirect_pc  = {redirect_raw[ADDR_W-1:2], 2'b00};
        at_last_word = (pc_q == LAST_PC);
        restart      = (state_q == HALTED) && start;
    end

    // Sequencer FSM: halt > stall > jump > branch > sequential, with overrun detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC_A;
            overrun_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (imem_halt) begin
                        state_q <= HALTED;
                    end else if (!stall) begin
                        if (redirect) begin
                            pc_q <= redirect_pc;
                            if (redirect_raw[1:0] != 2'b00) begin
                                misaligned_q <= 1'b1;
                            end
                        end else if (at_last_word) begin
                            overrun_q <= 1'b1;
                            state_q   <= HALTED;
                        end else begin
                            pc_q <= pc_q + ADDR_W'(WORD_BYTES);
                        end
                    end
                end
                HALTED: begin
                    if (start) begin
                        pc_q         <= RESET_PC_A;
                        overrun_q    <= 1'b0;
                        misaligned_q <= 1'b0;
                        state_q      <= RUN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (restart),
        .inc_i   (in_run),
        .count_o (cycle_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_retired_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (restart),
        .inc_i   (advance),
        .count_o (retired_count)
    );

    assign pc          = pc_q;
    assign instr_valid = in_run && !imem_halt;
    assign instr       = instr_valid ? imem_instr : '0;
    assign halted      = (state_q == HALTED);
    assign overrun     = overrun_q;
    assign misaligned  = misaligned_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter and sequences the byte-addressed, combinational-read instruction memory in the single-cycle MIPS core.
- Drives the memory PC and gates its instruction and halt outputs into the decode stage.
- Applies stall and branch/jump redirects, and detects halt and PC overrun.
- Keeps cycle and retired-instruction counters for test benches.

Parameters:
ADDR_W, 6, PC / instruction-memory byte-address width (64-byte memory)
CNT_W, 16, width of cycle_count and retired_count
RESET_PC, 0, PC loaded on reset and on restart; must be word aligned

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  pulse: IDLE->RUN, or restart from HALTED
stall  in  1  hold PC this cycle (downstream not ready)
jump  in  1  unconditional redirect request
jump_target  in  ADDR_W  jump destination byte address
branch_taken  in  1  taken-branch redirect request
branch_target  in  ADDR_W  branch destination byte address
imem_instr  in  32  instruction word from memory at pc
imem_halt  in  1  memory halt flag (word zero or X)
pc  out  ADDR_W  byte address to instruction memory
instr  out  32  instruction to decode; 0 when instr_valid=0
instr_valid  out  1  instr is executable this cycle
halted  out  1  state==HALTED
overrun  out  1  sticky: sequential fetch ran past last word
misaligned  out  1  sticky: redirect target had nonzero [1:0]
cycle_count  out  CNT_W  cycles spent in RUN, saturating
retired_count  out  CNT_W  instructions advanced past, saturating

Behaviour:
- States: IDLE, RUN, HALTED; state, pc, flags and counters are registered.
- rst (async) result:
  - state=IDLE, pc=RESET_PC.
  - overrun=0, misaligned=0, both counters=0.
  - instr_valid=0, instr=0.
- rst mid-RUN aborts immediately, with no partial update.
- instr_valid = (state==RUN) && !imem_halt, combinational.
- instr = instr_valid ? imem_instr : 0.
- Fetch latency is 0 cycles: the memory read is combinational on pc.
- IDLE: pc held. start=1 -> RUN next edge.
- RUN, each rising edge, in priority order:
  1. imem_halt=1 -> HALTED; pc held; no retire. Halt beats stall, jump and branch.
  2. stall=1 -> pc held, no retire; redirect inputs are ignored (not queued). cycle_count still increments.
  3. jump=1 -> pc<=jump_target with [1:0] forced 0. Jump beats branch.
  4. branch_taken=1 -> pc<=branch_target with [1:0] forced 0.
  5. Otherwise pc<=pc+4.
- Any advance (steps 3–5) increments retired_count.
- A redirect target with [1:0]!=0 sets misaligned; the redirect still happens.
- Overrun: pc = 2**ADDR_W-4 with a sequential advance (step 5) -> overrun=1, state=HALTED, pc held; the instruction still retires. A redirect from the last word is legal and does not set overrun.
- cycle_count increments every edge in RUN, including the halting edge. Both counters saturate at all-ones.
- HALTED:
  - pc, counters and flags hold; instr_valid=0; halted=1.
  - start=1 -> pc<=RESET_PC, counters<=0, overrun/misaligned<=0, state<=RUN.
- start while in RUN is ignored.
- rst has priority over every input.

Decomposition:
- Shared package core_pkg holds:
  - typedef enum fetch_state_t {IDLE, RUN, HALTED};
  - localparam INSTR_W=32 and WORD_BYTES=4.
- One natural sub-module: sat_counter (parameter width; inc, clr inputs), instantiated twice for the two counters.
- Next-PC mux and FSM stay inline.

Test Plan:
- Reset and idle: assert rst mid-cycle -> pc=0, instr_valid=0, counters 0 asynchronously; no start for 5 cycles -> pc stays 0.
- Straight-line run: memory words at 0,4,8 nonzero and word 12 = 0; pulse start -> pc goes 0,4,8,12; instr_valid=1 for 3 cycles, then HALTED; retired_count=3, cycle_count=4.
- Redirect priority: at pc=8 assert jump=1, jump_target=0x20, branch_taken=1, branch_target=0x10 -> pc=0x20. Next cycle branch_target=0x13 -> pc=0x10, misaligned=1.
- Stall: at pc=4 hold stall=1 for 3 cycles with jump=1 -> pc stays 4, retired_count unchanged, cycle_count +3; release with no redirect -> pc=8.
- Overrun: all words nonzero, run from 0 -> after the word at 60 retires, overrun=1, halted=1, pc=60, retired_count=16.
- Restart and mid-run reset: start in HALTED -> pc=0, flags and counters cleared, RUN. Assert rst at pc=0x14 -> IDLE, pc=0 immediately.
